cond_route_demux: RTL and testbench
===================================

// Module: cond_route_demux
// PURPOSE
//   Splitting counterpart of the nested-conditional selector.
//   - Selector: picks one of three sources by comparing y against z.
//   - This block: takes one data word plus a (y,z) compare pair and routes the word to one of three
//     registered output channels.
//   - Lets the coverage diags exercise both conditional arms and the compare subexpressions in a
//     clocked, handshaked context.
// PARAMETERS
//   CW     4   width of compare operands y, z
//   DW     2   width of data word a and of each output channel
//   CNT_W  8   width of per-channel route counters (stats option only)
// PORTS
//   clock       in   1     rising-edge clock
//   reset_n     in   1     asynchronous active-low reset
//   y           in   CW    compare operand (unsigned)
//   z           in   CW    compare operand (unsigned)
//   a           in   DW    data word to route
//   in_valid    in   1     a/y/z valid this cycle
//   in_ready    out  1     block can accept a/y/z this cycle
//   b, c, d     out  DW    channel data registers (y<z, y>z, y==z)
//   b_valid     out  1     b holds an undelivered word (c_valid, d_valid likewise)
//   b_ready     in   1     sink accepts b (c_ready, d_ready likewise)
//   last_sel    out  2     channel of most recent accepted word: 0=b 1=c 2=d 3=none yet
//   b_cnt, c_cnt, d_cnt  out  CNT_W  words routed per channel (stats option only)
// BEHAVIOUR
//   - Reset (reset_n low, async):
//     - b, c, d, b_valid, c_valid, d_valid = 0; last_sel = 2'd3; all counters = 0.
//     - In-flight words are discarded.
//   - sel is combinational, unsigned compare, priority order:
//     - y<z  -> b
//     - else y>z -> c
//     - else -> d
//   - Per channel X, state is a 1-bit slot with two states:
//     - EMPTY (X_valid=0)
//     - FULL (X_valid=1)
//   - in_ready = slot[sel] is EMPTY, or X_ready is high this cycle.
//     - Depends only on sel and that channel; other channels never stall the input.
//   - Accept = in_valid & in_ready. On accept, at the next clock edge:
//     - slot[sel] <= a and its valid is set.
//     - last_sel <= sel.
//   - Latency: 1 cycle from accept to X_valid=1.
//   - Drain:
//     - X_valid & X_ready clears X_valid at the edge, unless a same-cycle accept targets X.
//     - On a simultaneous drain and accept to the same channel, X_valid stays 1 and X loads the
//       new word (full-throughput pass-through).
//   - While X_valid=1 and X_ready=0:
//     - X holds its value.
//     - in_ready=0 whenever sel==X.
//   - Channels drain independently; several channels may drain in the same cycle.
//   - in_valid=0: sel is ignored, no state change except drains. in_ready is still driven.
//   - y, z, a are only sampled on accept; changes while stalled have no effect on stored data.
// CONFIGURATION
//   - Macro COND_ROUTE_STATS_EN:
//     - Defined:
//       - b_cnt/c_cnt/d_cnt increment by 1 on each accept to that channel.
//       - Counters saturate at 2**CNT_W-1 (no wrap).
//       - Counters reset to 0 on reset_n.
//     - Undefined:
//       - Counter ports are still present and tied to 0.
//       - No counter flops are inferred.
//   - Routing and handshake behaviour is identical in both builds.
// TESTING
//   1. y=3,z=5,a=0,in_valid=1, all ready=1
//      -> next cycle b_valid=1, b=0, last_sel=0.
//      Then y=5,z=5,a=2 -> d_valid=1, d=2, last_sel=2.
//   2. y=6,z=5,a=1 for 3 back-to-back cycles, c_ready=1
//      -> c_valid stays 1, c=1 each cycle, in_ready=1 throughout.
//   3. c_ready=0; send y=9,z=1,a=1 then y=9,z=1,a=3
//      -> second beat stalls (in_ready=0), c holds 1.
//      Switch the held input to y=0,z=0,a=2 -> in_ready=1, d=2 next cycle.
//   4. With b, c, d all FULL, assert all ready plus an accept to b (a=3)
//      -> c_valid=d_valid=0, b_valid=1, b=3.
//   5. Load b, c, d; pulse reset_n low mid-stream (not on a clock edge)
//      -> all valids=0, last_sel=3 immediately; first post-reset accept behaves as in test 1.
//   6. COND_ROUTE_STATS_EN defined, CNT_W=8: 300 accepts to d
//      -> d_cnt=255, b_cnt=c_cnt=0.
//      Undefined: all counters stay 0.

Source files
------------

// File: rtl/cond_route_demux_if.sv
//------------------------------------------------------------------------------
// Module : cond_route_demux_if
// Brief  : Input beat, three routed output channels and stats counters.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface cond_route_demux_if #(
    parameter int CW    = 4,
    parameter int DW    = 2,
    parameter int CNT_W = 8
);
    logic [CW-1:0]    y;
    logic [CW-1:0]    z;
    logic [DW-1:0]    a;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    b;
    logic [DW-1:0]    c;
    logic [DW-1:0]    d;
    logic             b_valid;
    logic             c_valid;
    logic             d_valid;
    logic             b_ready;
    logic             c_ready;
    logic             d_ready;
    logic [1:0]       last_sel;
    logic [CNT_W-1:0] b_cnt;
    logic [CNT_W-1:0] c_cnt;
    logic [CNT_W-1:0] d_cnt;

    modport master (
        output y, z, a, in_valid, b_ready, c_ready, d_ready,
        input  in_ready, b, c, d, b_valid, c_valid, d_valid, last_sel,
        input  b_cnt, c_cnt, d_cnt
    );

    modport slave (
        input  y, z, a, in_valid, b_ready, c_ready, d_ready,
        output in_ready, b, c, d, b_valid, c_valid, d_valid, last_sel,
        output b_cnt, c_cnt, d_cnt
    );
endinterface

`default_nettype wire

// File: rtl/cond_route_demux.sv
//------------------------------------------------------------------------------
// Module : cond_route_demux
// Brief  : Routes word a to channel b (y<z), c (y>z) or d (y==z), one slot each.
//          Macro COND_ROUTE_STATS_EN enables saturating per-channel counters.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cond_route_demux #(
    parameter int CW    = 4,
    parameter int DW    = 2,
    parameter int CNT_W = 8
) (
    input  wire                    clock,
    input  wire                    reset_n,
    cond_route_demux_if.slave      bus
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    logic [CW-1:0] w_y;
    logic [CW-1:0] w_z;
    logic [1:0]    w_sel;
    logic [2:0]    w_sel_oh;
    logic [2:0]    w_full;
    logic [2:0]    w_rdy;
    logic          w_in_ready;
    logic          w_accept;
    logic [1:0]    r_last_sel;

    assign w_y = bus.y;
    assign w_z = bus.z;

    // Priority compare: less-than wins, then greater-than, equality last.
    always_comb begin
        w_sel = 2'd2;
        if (w_y < w_z) begin
            w_sel = 2'd0;
        end else if (w_y > w_z) begin
            w_sel = 2'd1;
        end
    end

    assign w_sel_oh   = {w_sel == 2'd2, w_sel == 2'd1, w_sel == 2'd0};
    assign w_rdy      = {bus.d_ready, bus.c_ready, bus.b_ready};
    assign w_in_ready = |(w_sel_oh & (~w_full | w_rdy));
    assign w_accept   = bus.in_valid & w_in_ready;

    for (genvar i = 0; i < 3; i++) begin : g_chan
        slot_e          r_state;
        slot_e          w_state_nxt;
        logic [DW-1:0]  r_data;
        logic           w_acc;
        logic           w_drain;

        assign w_acc   = w_accept & w_sel_oh[i];
        assign w_drain = (r_state == FULL) & w_rdy[i];

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_state <= EMPTY;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        // A same-cycle accept overrides the drain so the slot passes through.
        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                EMPTY:   if (w_acc) w_state_nxt = FULL;
                FULL:    if (w_drain && !w_acc) w_state_nxt = EMPTY;
                default: w_state_nxt = EMPTY;
            endcase
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_data <= '0;
            end else if (w_acc) begin
                r_data <= bus.a;
            end
        end

`ifdef COND_ROUTE_STATS_EN
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt <= '0;
            end else if (w_acc && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
`endif
    end

    assign w_full = {g_chan[2].r_state == FULL,
                     g_chan[1].r_state == FULL,
                     g_chan[0].r_state == FULL};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_sel <= 2'd3;
        end else if (w_accept) begin
            r_last_sel <= w_sel;
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.b        = g_chan[0].r_data;
    assign bus.c        = g_chan[1].r_data;
    assign bus.d        = g_chan[2].r_data;
    assign bus.b_valid  = w_full[0];
    assign bus.c_valid  = w_full[1];
    assign bus.d_valid  = w_full[2];
    assign bus.last_sel = r_last_sel;

`ifdef COND_ROUTE_STATS_EN
    assign bus.b_cnt = g_chan[0].r_cnt;
    assign bus.c_cnt = g_chan[1].r_cnt;
    assign bus.d_cnt = g_chan[2].r_cnt;
`else
    assign bus.b_cnt = '0;
    assign bus.c_cnt = '0;
    assign bus.d_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cond_route_demux.sv
//------------------------------------------------------------------------------
// Module : tb_cond_route_demux
// Brief  : Directed and random stimulus against a behavioural channel model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cond_route_demux;

    localparam int CW    = 4;
    localparam int DW    = 2;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clock;
    logic reset_n;

    cond_route_demux_if #(.CW(CW), .DW(DW), .CNT_W(CNT_W)) bus ();

    cond_route_demux #(.CW(CW), .DW(DW), .CNT_W(CNT_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: one slot per channel, plus last route and counts.
    bit          m_full [3];
    bit [DW-1:0] m_data [3];
    int          m_cnt  [3];
    int          m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int route(input int yy, input int zz);
        if (yy < zz) return 0;
        if (yy > zz) return 1;
        return 2;
    endfunction

    function automatic bit ch_ready(input int ch);
        case (ch)
            0:       return bus.b_ready;
            1:       return bus.c_ready;
            default: return bus.d_ready;
        endcase
    endfunction

    function automatic bit model_in_ready();
        int s;
        s = route(int'(bus.y), int'(bus.z));
        return !m_full[s] || ch_ready(s);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_full[i] = 0;
            m_data[i] = '0;
            m_cnt[i]  = 0;
        end
        m_last = 3;
    endtask

    // Called right after a rising edge; inputs are unchanged since the edge.
    task automatic model_clock();
        int  s;
        bit  acc;
        s   = route(int'(bus.y), int'(bus.z));
        acc = bus.in_valid && model_in_ready();
        for (int i = 0; i < 3; i++)
            if (m_full[i] && ch_ready(i)) m_full[i] = 0;
        if (acc) begin
            m_full[s] = 1;
            m_data[s] = bus.a;
            m_last    = s;
            if (m_cnt[s] < CNT_MAX) m_cnt[s]++;
        end
    endtask

    task automatic check_outputs();
        int ec [3];
        for (int i = 0; i < 3; i++) begin
`ifdef COND_ROUTE_STATS_EN
            ec[i] = m_cnt[i];
`else
            ec[i] = 0;
`endif
        end
        chk("b_valid",  32'(bus.b_valid),  32'(m_full[0]));
        chk("c_valid",  32'(bus.c_valid),  32'(m_full[1]));
        chk("d_valid",  32'(bus.d_valid),  32'(m_full[2]));
        chk("b",        32'(bus.b),        32'(m_data[0]));
        chk("c",        32'(bus.c),        32'(m_data[1]));
        chk("d",        32'(bus.d),        32'(m_data[2]));
        chk("last_sel", 32'(bus.last_sel), 32'(m_last));
        chk("b_cnt",    32'(bus.b_cnt),    32'(ec[0]));
        chk("c_cnt",    32'(bus.c_cnt),    32'(ec[1]));
        chk("d_cnt",    32'(bus.d_cnt),    32'(ec[2]));
    endtask

    // One cycle: drive at falling edge, check in_ready, clock, check outputs.
    task automatic step(input bit v, input int yy, input int zz, input int aa,
                        input bit rb, input bit rc, input bit rd);
        @(negedge clock);
        bus.in_valid = v;
        bus.y        = CW'(yy);
        bus.z        = CW'(zz);
        bus.a        = DW'(aa);
        bus.b_ready  = rb;
        bus.c_ready  = rc;
        bus.d_ready  = rd;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(model_in_ready()));
        @(posedge clock);
        model_clock();
        #1;
        check_outputs();
    endtask

    task automatic mid_reset();
        @(negedge clock);
        bus.in_valid = 1'b0;
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        #1 reset_n = 1'b1;
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.y        = '0;
        bus.z        = '0;
        bus.a        = '0;
        bus.b_ready  = 1'b0;
        bus.c_ready  = 1'b0;
        bus.d_ready  = 1'b0;
        model_reset();
        #12;
        check_outputs();
        reset_n = 1'b1;

        // Basic routing to b then d
        step(1, 3, 5, 0, 1, 1, 1);
        step(1, 5, 5, 2, 1, 1, 1);
        // Back-to-back pass-through on c
        repeat (3) step(1, 6, 5, 1, 1, 1, 1);
        // Stall on c, then switch held beat to d
        step(1, 9, 1, 1, 1, 0, 1);
        step(1, 9, 1, 3, 1, 0, 1);
        step(1, 9, 1, 3, 1, 0, 1);
        step(1, 0, 0, 2, 1, 0, 1);
        // Fill all three, then drain all with accept to b
        step(1, 1, 2, 1, 0, 0, 0);
        step(1, 2, 1, 2, 0, 0, 0);
        step(1, 4, 4, 0, 0, 0, 0);
        step(1, 0, 9, 2, 0, 0, 0);
        step(1, 0, 9, 3, 1, 1, 1);
        step(0, 0, 0, 0, 1, 1, 1);
        // Reload, asynchronous reset mid-stream, then first accept again
        step(1, 1, 2, 1, 0, 0, 0);
        step(1, 2, 1, 2, 0, 0, 0);
        step(1, 4, 4, 3, 0, 0, 0);
        mid_reset();
        step(1, 3, 5, 0, 1, 1, 1);
        // Counter saturation on d
        repeat (300) step(1, 7, 7, 1, 1, 1, 1);

        // Random traffic with frequent equal operands and mixed backpressure
        for (int n = 0; n < 1500; n++) begin
            int yy, zz;
            yy = int'($urandom_range(0, 15));
            zz = ($urandom_range(0, 3) == 0) ? yy : int'($urandom_range(0, 15));
            step($urandom_range(0, 3) != 0, yy, zz, int'($urandom_range(0, 3)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 2) != 0);
            if (n == 700) mid_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
